// File: rtl/axi4_lite_regbank.sv
// AXI4-Lite slave register bank: RW/RO word slots, byte strobes,
// per-register access pulses and SLVERR/DECERR responses.
module axi4_lite_regbank #(
  parameter logic [31:0]           C_BASEADDR         = 32'h4000_0000,
  parameter int                    C_S_AXI_ADDR_WIDTH = 32,
  parameter int                    C_S_AXI_DATA_WIDTH = 32,
  parameter int                    C_NUM_REGS         = 16,
  parameter logic [C_NUM_REGS-1:0] C_RO_MASK          = '0
) (
  input  logic                                     S_AXI_ACLK,
  input  logic                                     S_AXI_ARESETN,
  input  logic [C_S_AXI_ADDR_WIDTH-1:0]            S_AXI_AWADDR,
  input  logic                                     S_AXI_AWVALID,
  output logic                                     S_AXI_AWREADY,
  input  logic [C_S_AXI_DATA_WIDTH-1:0]            S_AXI_WDATA,
  input  logic [C_S_AXI_DATA_WIDTH/8-1:0]          S_AXI_WSTRB,
  input  logic                                     S_AXI_WVALID,
  output logic                                     S_AXI_WREADY,
  output logic [1:0]                               S_AXI_BRESP,
  output logic                                     S_AXI_BVALID,
  input  logic                                     S_AXI_BREADY,
  input  logic [C_S_AXI_ADDR_WIDTH-1:0]            S_AXI_ARADDR,
  input  logic                                     S_AXI_ARVALID,
  output logic                                     S_AXI_ARREADY,
  output logic [C_S_AXI_DATA_WIDTH-1:0]            S_AXI_RDATA,
  output logic [1:0]                               S_AXI_RRESP,
  output logic                                     S_AXI_RVALID,
  input  logic                                     S_AXI_RREADY,
  output logic [C_NUM_REGS*C_S_AXI_DATA_WIDTH-1:0] reg_out,
  input  logic [C_NUM_REGS*C_S_AXI_DATA_WIDTH-1:0] reg_in,
  output logic [C_NUM_REGS-1:0]                    wr_stb,
  output logic [C_NUM_REGS-1:0]                    rd_stb
);

  localparam int AW  = C_S_AXI_ADDR_WIDTH;
  localparam int DW  = C_S_AXI_DATA_WIDTH;
  localparam int NB  = DW / 8;
  localparam int LSB = $clog2(NB);
  localparam int IW  = $clog2(C_NUM_REGS);

  localparam logic [AW-1:0] BASE = AW'(C_BASEADDR);
  localparam logic [AW-1:0] SPAN = AW'(C_NUM_REGS * NB);

  localparam logic [1:0] OKAY   = 2'b00;
  localparam logic [1:0] SLVERR = 2'b10;
  localparam logic [1:0] DECERR = 2'b11;

  typedef enum logic {RD_IDLE, RD_RESP} rd_state_t;

  logic clk;
  logic rst_n;

  assign clk   = S_AXI_ACLK;
  assign rst_n = S_AXI_ARESETN;

  logic [DW-1:0] regs [C_NUM_REGS];

  // ---------------- write path ----------------
  logic                  aw_full;
  logic                  w_full;
  logic                  bvalid;
  logic [1:0]            bresp;
  logic [AW-1:0]         aw_addr;
  logic [DW-1:0]         w_data;
  logic [NB-1:0]         w_strb;
  logic [C_NUM_REGS-1:0] wr_pulse;

  logic [AW-1:0] aw_off;
  logic          aw_hit;
  logic [IW-1:0] aw_idx;
  logic          commit;

  // Negative offsets wrap to huge values, so one compare covers both ends
  assign aw_off = aw_addr - BASE;
  assign aw_hit = aw_off < SPAN;
  assign aw_idx = aw_off[LSB +: IW];
  assign commit = aw_full && w_full && !bvalid;

  assign S_AXI_AWREADY = !aw_full && !bvalid;
  assign S_AXI_WREADY  = !w_full && !bvalid;
  assign S_AXI_BVALID  = bvalid;
  assign S_AXI_BRESP   = bresp;
  assign wr_stb        = wr_pulse;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      aw_full  <= 1'b0;
      w_full   <= 1'b0;
      aw_addr  <= '0;
      w_data   <= '0;
      w_strb   <= '0;
      bvalid   <= 1'b0;
      bresp    <= OKAY;
      wr_pulse <= '0;
      for (int i = 0; i < C_NUM_REGS; i++) regs[i] <= '0;
    end else begin
      wr_pulse <= '0;
      if (S_AXI_AWVALID && S_AXI_AWREADY) begin
        aw_full <= 1'b1;
        aw_addr <= S_AXI_AWADDR;
      end
      if (S_AXI_WVALID && S_AXI_WREADY) begin
        w_full <= 1'b1;
        w_data <= S_AXI_WDATA;
        w_strb <= S_AXI_WSTRB;
      end
      if (bvalid && S_AXI_BREADY) begin
        bvalid  <= 1'b0;
        aw_full <= 1'b0;
        w_full  <= 1'b0;
      end
      if (commit) begin
        bvalid <= 1'b1;
        if (!aw_hit) begin
          bresp <= DECERR;
        end else if (C_RO_MASK[aw_idx]) begin
          bresp <= SLVERR;
        end else begin
          bresp            <= OKAY;
          wr_pulse[aw_idx] <= 1'b1;
          for (int b = 0; b < NB; b++) begin
            if (w_strb[b]) regs[aw_idx][b*8 +: 8] <= w_data[b*8 +: 8];
          end
        end
      end
    end
  end

  for (genvar i = 0; i < C_NUM_REGS; i++) begin : g_out
    assign reg_out[i*DW +: DW] = C_RO_MASK[i] ? '0 : regs[i];
  end

  // ---------------- read path ----------------
  rd_state_t             rd_state;
  rd_state_t             rd_next;
  logic [DW-1:0]         rdata;
  logic [1:0]            rresp;
  logic [C_NUM_REGS-1:0] rd_pulse;

  logic [AW-1:0] ar_off;
  logic          ar_hit;
  logic [IW-1:0] ar_idx;
  logic          ar_hs;
  logic [DW-1:0] rd_word;

  assign ar_off  = S_AXI_ARADDR - BASE;
  assign ar_hit  = ar_off < SPAN;
  assign ar_idx  = ar_off[LSB +: IW];
  assign ar_hs   = S_AXI_ARVALID && S_AXI_ARREADY;
  assign rd_word = C_RO_MASK[ar_idx] ? reg_in[int'(ar_idx)*DW +: DW]
                                     : regs[ar_idx];

  assign S_AXI_RDATA = rdata;
  assign S_AXI_RRESP = rresp;
  assign rd_stb      = rd_pulse;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) rd_state <= RD_IDLE;
    else        rd_state <= rd_next;
  end

  always_comb begin
    rd_next       = rd_state;
    S_AXI_ARREADY = 1'b0;
    S_AXI_RVALID  = 1'b0;
    unique case (rd_state)
      RD_IDLE: begin
        S_AXI_ARREADY = 1'b1;
        if (S_AXI_ARVALID) rd_next = RD_RESP;
      end
      RD_RESP: begin
        S_AXI_RVALID = 1'b1;
        if (S_AXI_RREADY) rd_next = RD_IDLE;
      end
      default: rd_next = RD_IDLE;
    endcase
  end

  // Captured only at the AR edge, so data holds while RREADY is low
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      rdata    <= '0;
      rresp    <= OKAY;
      rd_pulse <= '0;
    end else begin
      rd_pulse <= '0;
      if (ar_hs) begin
        if (ar_hit) begin
          rdata            <= rd_word;
          rresp            <= OKAY;
          rd_pulse[ar_idx] <= 1'b1;
        end else begin
          rdata <= '0;
          rresp <= DECERR;
        end
      end
    end
  end

endmodule

// File: tb/tb_axi4_lite_regbank.sv
// Bench for axi4_lite_regbank: transaction-level model checked every
// cycle plus directed scenarios with literal expectations.
module tb_axi4_lite_regbank;

  localparam int AW = 32;
  localparam int DW = 32;
  localparam int N  = 16;
  localparam int SB = DW / 8;
  localparam logic [31:0]  BASE = 32'h4000_0000;
  localparam logic [N-1:0] RO   = 16'h0020;

  logic clk   = 1'b0;
  logic rst_n = 1'b1;

  logic [AW-1:0]   awaddr  = '0;
  logic            awvalid = 1'b0;
  logic            awready;
  logic [DW-1:0]   wdata   = '0;
  logic [SB-1:0]   wstrb   = '0;
  logic            wvalid  = 1'b0;
  logic            wready;
  logic [1:0]      bresp;
  logic            bvalid;
  logic            bready  = 1'b0;
  logic [AW-1:0]   araddr  = '0;
  logic            arvalid = 1'b0;
  logic            arready;
  logic [DW-1:0]   rdata;
  logic [1:0]      rresp;
  logic            rvalid;
  logic            rready  = 1'b0;
  logic [N*DW-1:0] reg_out;
  logic [N*DW-1:0] reg_in  = '0;
  logic [N-1:0]    wr_stb;
  logic [N-1:0]    rd_stb;

  always #5 clk = ~clk;

  axi4_lite_regbank #(
    .C_BASEADDR(BASE),
    .C_S_AXI_ADDR_WIDTH(AW),
    .C_S_AXI_DATA_WIDTH(DW),
    .C_NUM_REGS(N),
    .C_RO_MASK(RO)
  ) dut (
    .S_AXI_ACLK(clk),
    .S_AXI_ARESETN(rst_n),
    .S_AXI_AWADDR(awaddr),
    .S_AXI_AWVALID(awvalid),
    .S_AXI_AWREADY(awready),
    .S_AXI_WDATA(wdata),
    .S_AXI_WSTRB(wstrb),
    .S_AXI_WVALID(wvalid),
    .S_AXI_WREADY(wready),
    .S_AXI_BRESP(bresp),
    .S_AXI_BVALID(bvalid),
    .S_AXI_BREADY(bready),
    .S_AXI_ARADDR(araddr),
    .S_AXI_ARVALID(arvalid),
    .S_AXI_ARREADY(arready),
    .S_AXI_RDATA(rdata),
    .S_AXI_RRESP(rresp),
    .S_AXI_RVALID(rvalid),
    .S_AXI_RREADY(rready),
    .reg_out(reg_out),
    .reg_in(reg_in),
    .wr_stb(wr_stb),
    .rd_stb(rd_stb)
  );

  int errs   = 0;
  int checks = 0;
  int wr_cnt [N];
  int rd_cnt [N];

  task automatic chk(input string nm, input logic [63:0] act,
                     input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errs++;
      $display("FAIL %s: got %h expected %h (t=%0t)", nm, act, exp, $time);
    end
  endtask

  // Transaction-level model of the bank
  logic [DW-1:0] m_regs [N];
  logic          m_awf, m_wf, m_bv, m_rv;
  logic [AW-1:0] m_aaddr;
  logic [DW-1:0] m_wdata;
  logic [SB-1:0] m_wstrb;
  logic [1:0]    m_bresp, m_rresp;
  logic [DW-1:0] m_rdata;
  logic [N-1:0]  m_wrs, m_rds;

  function automatic int decode(input logic [AW-1:0] a);
    logic [AW-1:0] off;
    off = a - BASE;
    if (off >= AW'(N * SB)) return -1;
    return int'(off) / SB;
  endfunction

  always @(negedge clk) begin : compare
    int  k;
    bit  awh, wh, arh, cm, bh, rh;
    if (!rst_n) begin
      for (int i = 0; i < N; i++) m_regs[i] = '0;
      m_awf = 0; m_wf = 0; m_bv = 0; m_rv = 0;
      m_bresp = 0; m_rresp = 0; m_rdata = '0;
      m_wrs = '0; m_rds = '0;
      chk("rst_bresp", bresp, 0);
      chk("rst_rresp", rresp, 0);
      chk("rst_rdata", rdata, 0);
    end
    for (int i = 0; i < N; i++)
      chk($sformatf("reg_out[%0d]", i), reg_out[i*DW +: DW],
          RO[i] ? '0 : m_regs[i]);
    chk("awready", awready, !m_awf && !m_bv);
    chk("wready", wready, !m_wf && !m_bv);
    chk("arready", arready, !m_rv);
    chk("bvalid", bvalid, m_bv);
    if (m_bv) chk("bresp", bresp, m_bresp);
    chk("rvalid", rvalid, m_rv);
    if (m_rv) begin
      chk("rdata", rdata, m_rdata);
      chk("rresp", rresp, m_rresp);
    end
    chk("wr_stb", wr_stb, m_wrs);
    chk("rd_stb", rd_stb, m_rds);
    for (int i = 0; i < N; i++) begin
      wr_cnt[i] += int'(wr_stb[i]);
      rd_cnt[i] += int'(rd_stb[i]);
    end
    if (rst_n) begin
      awh = awvalid && !m_awf && !m_bv;
      wh  = wvalid && !m_wf && !m_bv;
      arh = arvalid && !m_rv;
      cm  = m_awf && m_wf && !m_bv;
      bh  = m_bv && bready;
      rh  = m_rv && rready;
      m_wrs = '0;
      m_rds = '0;
      if (arh) begin
        k = decode(araddr);
        if (k < 0) begin
          m_rdata = '0;
          m_rresp = 2'b11;
        end else begin
          m_rdata = RO[k] ? reg_in[k*DW +: DW] : m_regs[k];
          m_rresp = 2'b00;
          m_rds[k] = 1'b1;
        end
        m_rv = 1;
      end else if (rh) begin
        m_rv = 0;
      end
      if (cm) begin
        k = decode(m_aaddr);
        if (k < 0) m_bresp = 2'b11;
        else if (RO[k]) m_bresp = 2'b10;
        else begin
          m_bresp = 2'b00;
          m_wrs[k] = 1'b1;
          for (int b = 0; b < SB; b++)
            if (m_wstrb[b]) m_regs[k][b*8 +: 8] = m_wdata[b*8 +: 8];
        end
        m_bv = 1;
      end
      if (bh) begin
        m_bv = 0; m_awf = 0; m_wf = 0;
      end
      if (awh) begin
        m_awf = 1; m_aaddr = awaddr;
      end
      if (wh) begin
        m_wf = 1; m_wdata = wdata; m_wstrb = wstrb;
      end
    end
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic wr(input logic [AW-1:0] a, input logic [DW-1:0] d,
                    input logic [SB-1:0] s, output logic [1:0] resp);
    int n;
    bit ad, wd;
    awaddr = a; wdata = d; wstrb = s;
    awvalid = 1; wvalid = 1; bready = 1;
    ad = 0; wd = 0; n = 0;
    while (!(ad && wd) && n < 20) begin
      @(negedge clk);
      if (awvalid && awready) ad = 1;
      if (wvalid && wready) wd = 1;
      @(posedge clk);
      #1;
      if (ad) awvalid = 0;
      if (wd) wvalid = 0;
      n++;
    end
    awvalid = 0; wvalid = 0;
    chk("wr_hs_timeout", ad && wd, 1);
    n = 0;
    do begin
      @(negedge clk);
      n++;
    end while (!bvalid && n < 20);
    chk("wr_b_timeout", bvalid, 1);
    resp = bresp;
    @(posedge clk);
    #1;
    bready = 0;
  endtask

  task automatic rd(input logic [AW-1:0] a, output logic [DW-1:0] d,
                    output logic [1:0] resp);
    int n;
    bit hs;
    araddr = a; arvalid = 1; rready = 1;
    n = 0; hs = 0;
    while (!hs && n < 20) begin
      @(negedge clk);
      hs = arready;
      @(posedge clk);
      #1;
      n++;
    end
    arvalid = 0;
    chk("rd_ar_timeout", hs, 1);
    @(negedge clk);
    chk("rd_rvalid", rvalid, 1);
    d = rdata;
    resp = rresp;
    @(posedge clk);
    #1;
    rready = 0;
  endtask

  function automatic int sum(input int c [N]);
    int s = 0;
    for (int i = 0; i < N; i++) s += c[i];
    return s;
  endfunction

  initial begin : watchdog
    #200000;
    $display("FAIL watchdog: time limit reached");
    $fatal(1, "timeout");
  end

  initial begin : stim
    logic [1:0]    r;
    logic [DW-1:0] d;
    int            c0, bc;
    for (int i = 0; i < N; i++) reg_in[i*DW +: DW] = 32'h5A5A_0000 | 32'(i);
    reg_in[5*DW +: DW] = 32'hCAFE_0005;

    #2 rst_n = 0;
    repeat (3) tick();
    rst_n = 1;
    tick();

    // Reset in the middle of a write with BVALID pending
    wr(BASE + 4, 32'h1234_5678, 4'hF, r);
    chk("w1_resp", r, 2'b00);
    chk("w1_val", reg_out[1*DW +: DW], 32'h1234_5678);
    awaddr = BASE + 28; wdata = 32'h7777_7777; wstrb = 4'hF;
    awvalid = 1; wvalid = 1; bready = 0;
    tick();
    awvalid = 0; wvalid = 0;
    tick();
    @(negedge clk);
    chk("mid_bvalid", bvalid, 1);
    @(posedge clk);
    #1;
    rst_n = 0;
    @(negedge clk);
    chk("rst_bvalid", bvalid, 0);
    chk("rst_rvalid", rvalid, 0);
    chk("rst_awready", awready, 1);
    chk("rst_wready", wready, 1);
    chk("rst_arready", arready, 1);
    chk("rst_regs_zero", reg_out == '0, 1);
    chk("rst_strobes", {wr_stb, rd_stb}, 0);
    tick();
    rst_n = 1;
    tick();

    // AW two cycles before W, BREADY held off for four BVALID cycles
    c0 = wr_cnt[3];
    awaddr = BASE + 12; awvalid = 1;
    wdata = 32'hDEAD_BEEF; wstrb = 4'hF;
    tick();
    awvalid = 0;
    tick();
    wvalid = 1;
    tick();
    wvalid = 0;
    @(negedge clk);
    chk("w3_b_early", bvalid, 0);
    bc = 0;
    for (int i = 0; i < 4; i++) begin
      @(posedge clk);
      #1;
      if (i == 3) bready = 1;
      @(negedge clk);
      bc += int'(bvalid);
      chk("w3_bresp", bresp, 2'b00);
    end
    chk("w3_bvalid_cycles", bc, 4);
    @(negedge clk);
    chk("w3_b_done", bvalid, 0);
    tick();
    bready = 0;
    chk("w3_val", reg_out[3*DW +: DW], 32'hDEAD_BEEF);
    chk("w3_stb_count", wr_cnt[3] - c0, 1);

    // Byte-lane partial write and readback
    wr(BASE + 12, 32'h1122_3344, 4'b0101, r);
    chk("pw_resp", r, 2'b00);
    chk("pw_val", reg_out[3*DW +: DW], 32'hDE22_BE44);
    c0 = rd_cnt[3];
    rd(BASE + 12, d, r);
    chk("pw_rdata", d, 32'hDE22_BE44);
    chk("pw_rresp", r, 2'b00);
    chk("pw_rd_stb", rd_cnt[3] - c0, 1);

    // Read-only slot
    c0 = wr_cnt[5];
    wr(BASE + 20, 32'hFFFF_FFFF, 4'hF, r);
    chk("ro_bresp", r, 2'b10);
    chk("ro_no_stb", wr_cnt[5] - c0, 0);
    chk("ro_reg_out", reg_out[5*DW +: DW], 32'h0);
    rd(BASE + 20, d, r);
    chk("ro_rdata", d, 32'hCAFE_0005);
    chk("ro_rresp", r, 2'b00);

    // Out of range above and below the bank
    c0 = sum(wr_cnt);
    wr(BASE + 64, 32'hAAAA_AAAA, 4'hF, r);
    chk("oor_hi_bresp", r, 2'b11);
    wr(BASE - 4, 32'hBBBB_BBBB, 4'hF, r);
    chk("oor_lo_bresp", r, 2'b11);
    chk("oor_no_wr_stb", sum(wr_cnt) - c0, 0);
    chk("oor_reg3_kept", reg_out[3*DW +: DW], 32'hDE22_BE44);
    c0 = sum(rd_cnt);
    rd(BASE + 64, d, r);
    chk("oor_hi_rdata", d, 32'h0);
    chk("oor_hi_rresp", r, 2'b11);
    rd(BASE - 4, d, r);
    chk("oor_lo_rdata", d, 32'h0);
    chk("oor_lo_rresp", r, 2'b11);
    chk("oor_no_rd_stb", sum(rd_cnt) - c0, 0);

    // Read and write of the same register on the same edge
    wr(BASE + 8, 32'h0000_2222, 4'hF, r);
    awaddr = BASE + 8; wdata = 32'h0BAD_F00D; wstrb = 4'hF;
    awvalid = 1; wvalid = 1; bready = 1;
    araddr = BASE + 8; arvalid = 1; rready = 0;
    tick();
    awvalid = 0; wvalid = 0; arvalid = 0;
    for (int i = 0; i < 3; i++) begin
      @(negedge clk);
      chk("same_rvalid", rvalid, 1);
      chk("same_rdata_old", rdata, 32'h0000_2222);
      @(posedge clk);
      #1;
    end
    rready = 1;
    tick();
    rready = 0;
    bready = 0;
    chk("same_new_val", reg_out[2*DW +: DW], 32'h0BAD_F00D);
    rd(BASE + 8, d, r);
    chk("same_rdata_new", d, 32'h0BAD_F00D);

    repeat (3) tick();
    $display("Result: errors=%0d of %0d checks", errs, checks);
    $finish;
  end

endmodule
